aesl_deadlock_watchdog: RTL and testbench

Simulation-side watchdog that consumes the registered `block` flag from the top-level dataflow deadlock monitor and qualifies it over time. A deadlock is declared only after `block` stays asserted for a programmable number of consecutive cycles. On declaration the block latches a timestamp and an event count, plus an optional snapshot of the raw idle/block vectors, for the testbench to report. It sits directly downstream of the top-level deadlock monitor in the `pfb_multichannel` simulation harness.

---
 rtl/aesl_deadlock_watchdog.sv | 159 +++++++++++++++
 tb/tb_aesl_deadlock_watchdog.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_watchdog.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_watchdog
//
// Qualifies the registered `block` flag from the top-level dataflow deadlock
// monitor. A deadlock is declared only after block_in has been sampled high
// on THRESHOLD consecutive rising edges. On declaration the block latches the
// free-running cycle timestamp, bumps a saturating event counter and
// (optionally) snapshots the raw idle/block vectors. FIRED is sticky until
// `clear` re-arms the watchdog.
//
// Optional feature macro: AESL_DEADLOCK_SNAPSHOT_EN
//   defined   -> snap_* registers capture the input vectors at declaration
//   undefined -> snap_* outputs are constant 0, no snapshot flops exist
//
// Ports:
//   clock            in  1        rising-edge clock
//   reset            in  1        asynchronous, active-high reset
//   block_in         in  1        registered block flag from the monitor
//   axis_block_sigs  in  AXIS_W   raw AXIS block vector (snapshot source)
//   inst_idle_sigs   in  IDLE_W   raw process idle vector (snapshot source)
//   inst_block_sigs  in  BLK_W    raw channel block vector (snapshot source)
//   clear            in  1        synchronous acknowledge / re-arm
//   deadlock         out 1        qualified deadlock flag
//   state            out 2        0 = IDLE, 1 = ARMED, 2 = FIRED
//   fire_cycle       out CNT_W    cycle timestamp latched at declaration
//   event_count      out 8        declarations since reset, saturates at 255
//   snap_axis/idle/block          snapshot taken at declaration
// ---------------------------------------------------------------------------
module aesl_deadlock_watchdog #(
    parameter int THRESHOLD = 1000,
    parameter int CNT_W     = 32,
    parameter int AXIS_W    = 12,
    parameter int IDLE_W    = 19,
    parameter int BLK_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block_in,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [IDLE_W-1:0] inst_idle_sigs,
    input  logic [BLK_W-1:0]  inst_block_sigs,
    input  logic              clear,
    output logic              deadlock,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  fire_cycle,
    output logic [7:0]        event_count,
    output logic [AXIS_W-1:0] snap_axis,
    output logic [IDLE_W-1:0] snap_idle,
    output logic [BLK_W-1:0]  snap_block
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESHOLD - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cycle_ctr;
    logic [CNT_W-1:0] persist;
    logic             fire_hit;

    // Declaration happens on this edge. clear masks block_in entirely, so a
    // threshold hit coinciding with clear is dropped.
    always_comb begin
        fire_hit = 1'b0;
        if (!clear && block_in) begin
            if (state_q == S_IDLE && THRESHOLD == 1)
                fire_hit = 1'b1;
            else if (state_q == S_ARMED && persist == THRESH_M1)
                fire_hit = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cycle_ctr   <= '0;
            persist     <= '0;
            deadlock    <= 1'b0;
            fire_cycle  <= '0;
            event_count <= 8'd0;
        end else begin
            // Free-running timestamp; holds at all-ones rather than wrapping.
            if (cycle_ctr != {CNT_W{1'b1}})
                cycle_ctr <= cycle_ctr + 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (!clear && block_in) begin
                        if (fire_hit) begin
                            state_q <= S_FIRED;
                            persist <= '0;
                        end else begin
                            state_q <= S_ARMED;
                            persist <= CNT_W'(1);
                        end
                    end
                end
                S_ARMED: begin
                    if (clear || !block_in) begin
                        // Re-arm or glitch reject: no event recorded.
                        state_q <= S_IDLE;
                        persist <= '0;
                    end else if (fire_hit) begin
                        state_q <= S_FIRED;
                        persist <= '0;
                    end else begin
                        persist <= persist + 1'b1;
                    end
                end
                S_FIRED: begin
                    // Sticky: block_in is ignored, captured values held.
                    if (clear) begin
                        state_q  <= S_IDLE;
                        deadlock <= 1'b0;
                        persist  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    persist <= '0;
                end
            endcase

            if (fire_hit) begin
                deadlock   <= 1'b1;
                fire_cycle <= cycle_ctr;
                if (event_count != 8'hFF)
                    event_count <= event_count + 8'd1;
            end
        end
    end

    assign state = state_q;

`ifdef AESL_DEADLOCK_SNAPSHOT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_axis  <= '0;
            snap_idle  <= '0;
            snap_block <= '0;
        end else if (fire_hit) begin
            snap_axis  <= axis_block_sigs;
            snap_idle  <= inst_idle_sigs;
            snap_block <= inst_block_sigs;
        end
    end
`else
    // Snapshot disabled: outputs are constant zero. The inputs are still
    // referenced so the port list stays identical in both builds.
    assign snap_axis  = axis_block_sigs & {AXIS_W{1'b0}};
    assign snap_idle  = inst_idle_sigs  & {IDLE_W{1'b0}};
    assign snap_block = inst_block_sigs & {BLK_W{1'b0}};
`endif

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// ---------------------------------------------------------------------------
// Directed bench for aesl_deadlock_watchdog. Two instances share clock,
// reset and input vectors: dut4 (THRESHOLD=4, CNT_W=32) and dut1
// (THRESHOLD=1, CNT_W=4, so the timestamp saturates quickly).
// Edge numbering: edge 0 is the first rising edge after reset release.
// ---------------------------------------------------------------------------
module tb_aesl_deadlock_watchdog;

`ifdef AESL_DEADLOCK_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // shared vectors
    logic [11:0] axis_v  = '0;
    logic [18:0] idle_v  = '0;
    logic [15:0] blk_v   = '0;

    // dut4 signals
    logic        block4 = 1'b0, clear4 = 1'b0;
    logic        dl4;
    logic [1:0]  st4;
    logic [31:0] fc4;
    logic [7:0]  ec4;
    logic [11:0] sa4;
    logic [18:0] si4;
    logic [15:0] sb4;

    // dut1 signals
    logic        block1 = 1'b0, clear1 = 1'b0;
    logic        dl1;
    logic [1:0]  st1;
    logic [3:0]  fc1;
    logic [7:0]  ec1;
    logic [11:0] sa1;
    logic [18:0] si1;
    logic [15:0] sb1;

    int checks   = 0;
    int failures = 0;

    aesl_deadlock_watchdog #(.THRESHOLD(4), .CNT_W(32)) dut4 (
        .clock(clock), .reset(reset), .block_in(block4),
        .axis_block_sigs(axis_v), .inst_idle_sigs(idle_v), .inst_block_sigs(blk_v),
        .clear(clear4), .deadlock(dl4), .state(st4), .fire_cycle(fc4),
        .event_count(ec4), .snap_axis(sa4), .snap_idle(si4), .snap_block(sb4)
    );

    aesl_deadlock_watchdog #(.THRESHOLD(1), .CNT_W(4)) dut1 (
        .clock(clock), .reset(reset), .block_in(block1),
        .axis_block_sigs(axis_v), .inst_idle_sigs(idle_v), .inst_block_sigs(blk_v),
        .clear(clear1), .deadlock(dl1), .state(st1), .fire_cycle(fc1),
        .event_count(ec1), .snap_axis(sa1), .snap_idle(si1), .snap_block(sb1)
    );

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold reset across two edges, release on a falling edge; next posedge is edge 0.
    task automatic do_reset();
        reset  = 1'b1;
        block4 = 1'b0; clear4 = 1'b0;
        block1 = 1'b0; clear1 = 1'b0;
        axis_v = '0; idle_v = '0; blk_v = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({dl4, st4, fc4, ec4, sa4, si4, sb4} !== '0) begin failures++; $display("FAIL reset_dut4 got=%0h exp=0", {dl4, st4, fc4, ec4, sa4, si4, sb4}); end
        checks++; if ({dl1, st1, fc1, ec1, sa1, si1, sb1} !== '0) begin failures++; $display("FAIL reset_dut1 got=%0h exp=0", {dl1, st1, fc1, ec1, sa1, si1, sb1}); end
    endtask

    // 3 highs then a low: no declaration; next run must count from 1 again.
    task automatic test_glitch();
        do_reset();
        block4 = 1'b1;
        ticks(3);
        checks++; if (st4 !== 2'd1) begin failures++; $display("FAIL glitch_armed state got=%0d exp=1", st4); end
        block4 = 1'b0;
        tick();
        checks++; if (st4 !== 2'd0) begin failures++; $display("FAIL glitch_idle state got=%0d exp=0", st4); end
        checks++; if (dl4 !== 1'b0 || ec4 !== 8'd0) begin failures++; $display("FAIL glitch_noevent dl=%0b ec=%0d exp dl=0 ec=0", dl4, ec4); end
        block4 = 1'b1;
        ticks(3);
        checks++; if (dl4 !== 1'b0 || st4 !== 2'd1) begin failures++; $display("FAIL glitch_restart dl=%0b st=%0d exp dl=0 st=1", dl4, st4); end
        tick();
        checks++; if (dl4 !== 1'b1 || ec4 !== 8'd1) begin failures++; $display("FAIL glitch_refire dl=%0b ec=%0d exp dl=1 ec=1", dl4, ec4); end
    endtask

    // block_in high from edge 10 -> declared at edge 13, snapshot of edge-13 inputs.
    task automatic test_fire_timestamp();
        do_reset();
        ticks(10);                      // edges 0..9 with block low
        block4 = 1'b1;
        axis_v = 12'h111; idle_v = 19'h1_1111; blk_v = 16'h1111;
        ticks(3);                       // edges 10..12
        checks++; if (dl4 !== 1'b0 || st4 !== 2'd1) begin failures++; $display("FAIL fire_early dl=%0b st=%0d exp dl=0 st=1", dl4, st4); end
        axis_v = 12'hA5C; idle_v = 19'h5_1234; blk_v = 16'hBEEF;
        tick();                         // edge 13
        axis_v = 12'h0F0; idle_v = 19'h7_0F0F; blk_v = 16'h0F0F;
        checks++; if (dl4 !== 1'b1 || st4 !== 2'd2) begin failures++; $display("FAIL fire_flag dl=%0b st=%0d exp dl=1 st=2", dl4, st4); end
        checks++; if (fc4 !== 32'd13) begin failures++; $display("FAIL fire_cycle got=%0d exp=13", fc4); end
        checks++; if (ec4 !== 8'd1) begin failures++; $display("FAIL fire_count got=%0d exp=1", ec4); end
        checks++; if (si4 !== (SNAP ? 19'h5_1234 : 19'h0)) begin failures++; $display("FAIL snap_idle got=%0h exp=%0h", si4, SNAP ? 19'h5_1234 : 19'h0); end
        checks++; if ({sa4, sb4} !== (SNAP ? {12'hA5C, 16'hBEEF} : 28'h0)) begin failures++; $display("FAIL snap_axis_block got=%0h exp=%0h", {sa4, sb4}, SNAP ? {12'hA5C, 16'hBEEF} : 28'h0); end
    endtask

    // Continues from fire at edge 13: sticky hold, clear, re-fire at edge 21.
    task automatic test_sticky_clear();
        block4 = 1'b0; tick();          // edge 14
        block4 = 1'b1; axis_v = 12'h321; tick(); // edge 15
        block4 = 1'b0; idle_v = 19'h0_0042; tick(); // edge 16
        checks++; if (dl4 !== 1'b1 || st4 !== 2'd2 || fc4 !== 32'd13 || ec4 !== 8'd1) begin failures++; $display("FAIL sticky_hold dl=%0b st=%0d fc=%0d ec=%0d exp 1/2/13/1", dl4, st4, fc4, ec4); end
        checks++; if (si4 !== (SNAP ? 19'h5_1234 : 19'h0)) begin failures++; $display("FAIL sticky_snap got=%0h exp=%0h", si4, SNAP ? 19'h5_1234 : 19'h0); end
        block4 = 1'b1; clear4 = 1'b1;
        tick();                         // edge 17: clear
        clear4 = 1'b0;
        checks++; if (dl4 !== 1'b0 || st4 !== 2'd0) begin failures++; $display("FAIL clear_fired dl=%0b st=%0d exp dl=0 st=0", dl4, st4); end
        checks++; if (fc4 !== 32'd13 || ec4 !== 8'd1) begin failures++; $display("FAIL clear_hold fc=%0d ec=%0d exp fc=13 ec=1", fc4, ec4); end
        axis_v = 12'h777; idle_v = 19'h3_3333; blk_v = 16'h7777;
        ticks(3);                       // edges 18..20
        checks++; if (dl4 !== 1'b0 || st4 !== 2'd1) begin failures++; $display("FAIL refire_early dl=%0b st=%0d exp dl=0 st=1", dl4, st4); end
        tick();                         // edge 21
        checks++; if (dl4 !== 1'b1 || fc4 !== 32'd21 || ec4 !== 8'd2) begin failures++; $display("FAIL refire dl=%0b fc=%0d ec=%0d exp 1/21/2", dl4, fc4, ec4); end
        checks++; if (si4 !== (SNAP ? 19'h3_3333 : 19'h0)) begin failures++; $display("FAIL refire_snap got=%0h exp=%0h", si4, SNAP ? 19'h3_3333 : 19'h0); end
    endtask

    // clear on the threshold edge suppresses the declaration; clear in IDLE masks block_in.
    task automatic test_clear_priority();
        do_reset();
        block4 = 1'b1;
        ticks(3);                       // edges 0..2, persist=3
        clear4 = 1'b1;
        tick();                         // edge 3 would have fired
        checks++; if (dl4 !== 1'b0 || st4 !== 2'd0 || ec4 !== 8'd0) begin failures++; $display("FAIL clear_prio dl=%0b st=%0d ec=%0d exp 0/0/0", dl4, st4, ec4); end
        tick();                         // edge 4: clear in IDLE with block high
        checks++; if (st4 !== 2'd0) begin failures++; $display("FAIL clear_idle state got=%0d exp=0", st4); end
        clear4 = 1'b0;
        tick();                         // edge 5: counting starts
        checks++; if (st4 !== 2'd1 || dl4 !== 1'b0) begin failures++; $display("FAIL clear_rearm st=%0d dl=%0b exp st=1 dl=0", st4, dl4); end
        block4 = 1'b1; ticks(2);        // edges 6,7
        clear4 = 1'b1; tick(); clear4 = 1'b0; // edge 8: clear in ARMED
        checks++; if (st4 !== 2'd0 || ec4 !== 8'd0) begin failures++; $display("FAIL clear_armed st=%0d ec=%0d exp st=0 ec=0", st4, ec4); end
    endtask

    // THRESHOLD=1: a single-cycle pulse declares on that edge.
    task automatic test_threshold_one();
        do_reset();
        ticks(3);                       // edges 0..2
        block1 = 1'b1; blk_v = 16'hCAFE;
        tick();                         // edge 3
        block1 = 1'b0; blk_v = 16'h0000;
        checks++; if (dl1 !== 1'b1 || st1 !== 2'd2) begin failures++; $display("FAIL t1_fire dl=%0b st=%0d exp dl=1 st=2", dl1, st1); end
        checks++; if (fc1 !== 4'd3 || ec1 !== 8'd1) begin failures++; $display("FAIL t1_stamp fc=%0d ec=%0d exp fc=3 ec=1", fc1, ec1); end
        checks++; if (sb1 !== (SNAP ? 16'hCAFE : 16'h0)) begin failures++; $display("FAIL t1_snap got=%0h exp=%0h", sb1, SNAP ? 16'hCAFE : 16'h0); end
        ticks(2);
        checks++; if (dl1 !== 1'b1 || st1 !== 2'd2) begin failures++; $display("FAIL t1_sticky dl=%0b st=%0d exp dl=1 st=2", dl1, st1); end
    endtask

    // Continues in FIRED on dut1: 259 clear/fire pairs -> event_count saturates, timestamp saturates.
    task automatic test_saturation();
        block1 = 1'b1;
        for (int i = 0; i < 259; i++) begin
            clear1 = 1'b1; tick();
            clear1 = 1'b0; tick();
        end
        checks++; if (ec1 !== 8'd255) begin failures++; $display("FAIL event_sat got=%0d exp=255", ec1); end
        checks++; if (fc1 !== 4'd15) begin failures++; $display("FAIL cycle_sat got=%0d exp=15", fc1); end
        block1 = 1'b0;
    endtask

    // Asynchronous reset mid-ARMED and mid-FIRED, checked between clock edges.
    task automatic test_async_reset();
        do_reset();
        block4 = 1'b1;
        ticks(2);                       // ARMED
        #2 reset = 1'b1;
        #1;
        checks++; if ({dl4, st4, fc4, ec4, sa4, si4, sb4} !== '0) begin failures++; $display("FAIL areset_armed got=%0h exp=0", {dl4, st4, fc4, ec4, sa4, si4, sb4}); end
        @(negedge clock);
        reset = 1'b0;
        block1 = 1'b1;
        idle_v = 19'h2_AAAA;
        ticks(4);                       // dut4 fires at edge 3
        checks++; if (dl4 !== 1'b1 || fc4 !== 32'd3) begin failures++; $display("FAIL areset_restart dl=%0b fc=%0d exp dl=1 fc=3", dl4, fc4); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({dl4, st4, fc4, ec4, sa4, si4, sb4} !== '0) begin failures++; $display("FAIL areset_fired4 got=%0h exp=0", {dl4, st4, fc4, ec4, sa4, si4, sb4}); end
        checks++; if ({dl1, st1, fc1, ec1, sa1, si1, sb1} !== '0) begin failures++; $display("FAIL areset_fired1 got=%0h exp=0", {dl1, st1, fc1, ec1, sa1, si1, sb1}); end
        block4 = 1'b0; block1 = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    initial begin
        test_reset();
        test_glitch();
        test_fire_timestamp();
        test_sticky_clear();
        test_clear_priority();
        test_threshold_one();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
